// File: rtl/zvc_pkg.sv
// zvc_pkg: shared constants, types and helpers for the zero-value compressor.
//   LINE_SIZE_C       entries per line (fixed by the prefix adder)
//   COUNT_W           width of a kept-entry count (0..32)
//   *_C               default field geometry used to size stage_t
//   mtw()             MT entry width from distance width and field count
//   stage_t           one pipeline stage record {valid, lifm, mt, mask, count}
package zvc_pkg;

    localparam int LINE_SIZE_C      = 32;
    localparam int COUNT_W          = 6;
    localparam int WORD_WIDTH_C     = 8;
    localparam int DIST_WIDTH_C     = 7;
    localparam int MAX_LIFM_RSIZ_C  = 3;

    function automatic int mtw(input int dist_width, input int max_lifm_rsiz);
        return dist_width * max_lifm_rsiz;
    endfunction

    localparam int MTW_C = mtw(DIST_WIDTH_C, MAX_LIFM_RSIZ_C);

    typedef struct packed {
        logic                                valid;
        logic [LINE_SIZE_C*WORD_WIDTH_C-1:0] lifm;
        logic [LINE_SIZE_C*MTW_C-1:0]        mt;
        logic [LINE_SIZE_C-1:0]              mask;
        logic [COUNT_W-1:0]                  count;
    } stage_t;

endpackage

// File: rtl/lf_prefix_adder.sv
// lf_prefix_adder: 32-entry Ladner-Fischer (minimum-depth) prefix adder over a
// 1-bit mask. Purely combinational, log2(32) = 5 levels.
//   mask  in   32       input bits
//   psum  out  32*32    psum[32*i +: 32] = inclusive count of mask[0..i]
module lf_prefix_adder (
    input  logic [31:0]      mask,
    output logic [32*32-1:0] psum
);

    // lvl[l][i] = sum of mask over the aligned 2^l block of i, up to i.
    logic [5:0] lvl [0:5][0:31];

    for (genvar i = 0; i < 32; i++) begin : g_io
        assign lvl[0][i]        = {5'd0, mask[i]};
        assign psum[32*i +: 32] = {26'd0, lvl[5][i]};
    end

    for (genvar l = 0; l < 5; l++) begin : g_lvl
        for (genvar i = 0; i < 32; i++) begin : g_node
            if (((i >> l) & 1) == 1) begin : g_add
                // Upper half of a 2^(l+1) block absorbs the lower half's total.
                assign lvl[l+1][i] = lvl[l][i] + lvl[l][((i >> l) << l) - 1];
            end else begin : g_pass
                assign lvl[l+1][i] = lvl[l][i];
            end
        end
    end

endmodule

// File: rtl/zvc_scatter.sv
// zvc_scatter: combinational compaction of one line. Each kept entry i is
// written to slot psum_i - 1; untouched slots stay zero.
//   mask       in   32            keep mask
//   psum       in   32*COUNT_W    inclusive prefix counts of mask
//   lifm       in   32*WORD_WIDTH line of LIFM words
//   mt         in   32*MTW        line of MT entries
//   lifm_comp  out  32*WORD_WIDTH packed kept words, zero tail
//   mt_comp    out  32*MTW        packed kept MT entries, zero tail
//   count      out  COUNT_W       number of kept entries
module zvc_scatter
    import zvc_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int MTW        = 21
) (
    input  logic [LINE_SIZE_C-1:0]            mask,
    input  logic [LINE_SIZE_C*COUNT_W-1:0]    psum,
    input  logic [LINE_SIZE_C*WORD_WIDTH-1:0] lifm,
    input  logic [LINE_SIZE_C*MTW-1:0]        mt,
    output logic [LINE_SIZE_C*WORD_WIDTH-1:0] lifm_comp,
    output logic [LINE_SIZE_C*MTW-1:0]        mt_comp,
    output logic [COUNT_W-1:0]                count
);

    logic [4:0] dst;

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        lifm_comp = '0;
        mt_comp   = '0;
        dst       = '0;
        for (int i = 0; i < LINE_SIZE_C; i++) begin
            if (mask[i]) begin
                // Low 5 bits only: a count of 32 wraps to 0, giving slot 31.
                dst = 5'(psum[COUNT_W*i +: COUNT_W] - 6'd1);
                lifm_comp[WORD_WIDTH*dst +: WORD_WIDTH] = lifm[WORD_WIDTH*i +: WORD_WIDTH];
                mt_comp[MTW*dst +: MTW]                 = mt[MTW*i +: MTW];
            end
        end
    end

    assign count = psum[COUNT_W*(LINE_SIZE_C-1) +: COUNT_W];

endmodule

// File: rtl/zv_compressor.sv
// zv_compressor: three-stage zero-value compressor. Entries whose MT entry is
// nonzero are packed toward slot 0 in original order; the tail is zero.
//   S0 input line -> prefix adder -> S1 mask/psum/line -> scatter -> S2 output.
// All stages advance together when the output slot is empty or being taken.
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is combinational from out_ready)
//   lifm_line, mt_line    input line, entry i at [W*i +: W]
//   out_valid / out_ready output handshake
//   lifm_comp, mt_comp    compacted line
//   out_mask, out_count   original keep mask, number of kept entries
// Build option ZVC_STATS_EN adds stat_clr (in), stat_lines and stat_kept (out):
// handshake count and sum of out_count, wrapping, clear has priority.
module zv_compressor
    import zvc_pkg::*;
#(
    parameter int      WORD_WIDTH    = 8,
    parameter int      LINE_SIZE     = 32,
    parameter int      DIST_WIDTH    = 7,
    parameter int      MAX_LIFM_RSIZ = 3,
    localparam int     MTW           = mtw(DIST_WIDTH, MAX_LIFM_RSIZ)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_line,
    input  logic [LINE_SIZE*MTW-1:0]        mt_line,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LINE_SIZE*WORD_WIDTH-1:0] lifm_comp,
    output logic [LINE_SIZE*MTW-1:0]        mt_comp,
    output logic [LINE_SIZE-1:0]            out_mask,
    output logic [COUNT_W-1:0]              out_count
`ifdef ZVC_STATS_EN
    ,
    input  logic                            stat_clr,
    output logic [31:0]                     stat_lines,
    output logic [31:0]                     stat_kept
`endif
);

    // The prefix adder is 32 wide and stage_t is sized from the package.
    if (LINE_SIZE != LINE_SIZE_C || WORD_WIDTH != WORD_WIDTH_C || MTW != MTW_C) begin : g_cfg_err
        $error("zv_compressor: geometry must match zvc_pkg (LINE_SIZE 32)");
    end

    logic adv;

    logic                            s0_valid;
    logic [LINE_SIZE*WORD_WIDTH-1:0] s0_lifm;
    logic [LINE_SIZE*MTW-1:0]        s0_mt;
    logic [LINE_SIZE-1:0]            s0_mask;

    logic [32*32-1:0]                psum_full;
    logic [LINE_SIZE*COUNT_W-1:0]    psum_cnt;
    logic [LINE_SIZE*(32-COUNT_W)-1:0] psum_hi;
    logic                            unused_psum_hi;

    logic                            s1_valid;
    logic [LINE_SIZE*WORD_WIDTH-1:0] s1_lifm;
    logic [LINE_SIZE*MTW-1:0]        s1_mt;
    logic [LINE_SIZE-1:0]            s1_mask;
    logic [LINE_SIZE*COUNT_W-1:0]    s1_psum;

    logic [LINE_SIZE*WORD_WIDTH-1:0] comp_lifm;
    logic [LINE_SIZE*MTW-1:0]        comp_mt;
    logic [COUNT_W-1:0]              comp_count;

    stage_t s2;

    // Whole pipe moves when the output slot is empty or being consumed.
    assign adv      = !s2.valid || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: data registers are reset as well so every output reads zero in reset.
        if (!reset_n) begin
            s0_valid <= 1'b0;
            s0_lifm  <= '0;
            s0_mt    <= '0;
        end else if (adv) begin
            // NOTE: non-blocking so every stage samples its predecessor's old value.
            s0_valid <= in_valid;
            s0_lifm  <= lifm_line;
            s0_mt    <= mt_line;
        end
    end

    always_comb begin
        s0_mask = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            s0_mask[i] = |s0_mt[MTW*i +: MTW];
        end
    end

    lf_prefix_adder u_prefix (
        .mask (s0_mask),
        .psum (psum_full)
    );

    // Counts never exceed 32, so only the low COUNT_W bits of each field matter.
    always_comb begin
        psum_cnt = '0;
        psum_hi  = '0;
        for (int i = 0; i < LINE_SIZE; i++) begin
            psum_cnt[COUNT_W*i +: COUNT_W]          = psum_full[32*i +: COUNT_W];
            psum_hi[(32-COUNT_W)*i +: (32-COUNT_W)] = psum_full[32*i+COUNT_W +: (32-COUNT_W)];
        end
    end
    assign unused_psum_hi = ^psum_hi;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_lifm  <= '0;
            s1_mt    <= '0;
            s1_mask  <= '0;
            s1_psum  <= '0;
        end else if (adv) begin
            s1_valid <= s0_valid;
            s1_lifm  <= s0_lifm;
            s1_mt    <= s0_mt;
            s1_mask  <= s0_mask;
            s1_psum  <= psum_cnt;
        end
    end

    zvc_scatter #(
        .WORD_WIDTH (WORD_WIDTH),
        .MTW        (MTW)
    ) u_scatter (
        .mask      (s1_mask),
        .psum      (s1_psum),
        .lifm      (s1_lifm),
        .mt        (s1_mt),
        .lifm_comp (comp_lifm),
        .mt_comp   (comp_mt),
        .count     (comp_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2 <= '0;
        end else if (adv) begin
            s2 <= '{valid: s1_valid, lifm: comp_lifm, mt: comp_mt,
                    mask: s1_mask, count: comp_count};
        end
    end

    assign out_valid = s2.valid;
    assign lifm_comp = s2.lifm;
    assign mt_comp   = s2.mt;
    assign out_mask  = s2.mask;
    assign out_count = s2.count;

`ifdef ZVC_STATS_EN
    logic handshake;
    assign handshake = s2.valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_lines <= '0;
            stat_kept  <= '0;
        end else if (stat_clr) begin
            stat_lines <= '0;
            stat_kept  <= '0;
        end else if (handshake) begin
            stat_lines <= stat_lines + 32'd1;
            stat_kept  <= stat_kept + 32'(s2.count);
        end
    end
`endif

endmodule
